// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar arbiter: index widths, per-slave state, field slicing.
// Pure declarations; no timing or flow-control behaviour of its own.
package xbar_pkg;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } slv_state_t;

  // Field k of width w out of a packed vector (w <= 32, vector zero-extended to 256 bits).
  function automatic int unsigned fld(input logic [255:0] vec, input int k, input int w);
    logic [255:0] sh;
    sh = vec >> (k * w);
    return sh[31:0] & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick for one slave: keep the owner while it holds, else first requester after last.
// Zero latency; no backpressure, losing requesters simply stay pending.
module rr_arbiter
  import xbar_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  input  logic         hold,
  input  logic [W-1:0] owner,
  output logic [W-1:0] nxt_owner,
  output logic         nxt_vld
);

  int idx;

  always_comb begin
    nxt_owner = owner;
    nxt_vld   = 1'b0;
    idx       = 0;
    if (hold) begin
      nxt_vld = 1'b1;
    end else begin
      // Scan farthest-first so the nearest requester after last is written last and wins.
      for (int k = N; k >= 1; k--) begin
        idx = (int'(last) + k) % N;
        if (req[idx]) begin
          nxt_owner = W'(idx);
          nxt_vld   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/xbar_arbiter.sv
// Per-slave round-robin ownership for an M x S crossbar; grant appears one clock after request.
// No backpressure: an owner holds until it drops or retargets, losers keep requesting.
module xbar_arbiter
  import xbar_pkg::*;
#(
  parameter int  M  = 3,
  parameter int  S  = 2,
  localparam int MW = idx_w(M),
  localparam int SW = idx_w(S)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [M-1:0]    m_req,
  input  logic [SW*M-1:0] m_tgt,
  output logic [MW*S-1:0] m_sel_array,
  output logic [SW*M-1:0] s_sel_array,
  output logic [M-1:0]    m_grant,
  output logic [S-1:0]    s_owned
);

  logic [SW-1:0] tgt       [M];
  logic [M-1:0]  req_mat   [S];
  logic [MW-1:0] owner     [S];
  logic [MW-1:0] nxt_owner [S];
  logic [MW-1:0] last_q    [S];
  slv_state_t    st_q      [S];
  logic [S-1:0]  hold;
  logic [S-1:0]  nxt_vld;
  logic [M-1:0]  nxt_grant;

  always_comb begin
    for (int i = 0; i < M; i++) begin
      tgt[i] = SW'(fld(256'(m_tgt), i, SW));
    end
  end

  // Out-of-range targets never match any slave index, so they are never granted.
  always_comb begin
    for (int j = 0; j < S; j++) begin
      for (int i = 0; i < M; i++) begin
        req_mat[j][i] = m_req[i] && (int'(tgt[i]) == j);
      end
    end
  end

  // m_sel_array doubles as the owner register; it is only meaningful while OWNED.
  always_comb begin
    for (int j = 0; j < S; j++) begin
      owner[j] = m_sel_array[j*MW +: MW];
      hold[j]  = (st_q[j] == OWNED) && req_mat[j][owner[j]];
    end
  end

  for (genvar j = 0; j < S; j++) begin : g_slv
    rr_arbiter #(
      .N (M),
      .W (MW)
    ) u_rr (
      .req       (req_mat[j]),
      .last      (last_q[j]),
      .hold      (hold[j]),
      .owner     (owner[j]),
      .nxt_owner (nxt_owner[j]),
      .nxt_vld   (nxt_vld[j])
    );
    assign s_owned[j] = (st_q[j] == OWNED);
  end

  always_comb begin
    nxt_grant = '0;
    for (int j = 0; j < S; j++) begin
      if (nxt_vld[j]) begin
        nxt_grant[nxt_owner[j]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < S; j++) begin
        st_q[j]   <= IDLE;
        last_q[j] <= MW'(M - 1);
      end
      m_sel_array <= '0;
      s_sel_array <= '0;
      m_grant     <= '0;
    end else begin
      for (int j = 0; j < S; j++) begin
        st_q[j] <= nxt_vld[j] ? OWNED : IDLE;
        if (nxt_vld[j]) begin
          last_q[j]               <= nxt_owner[j];
          m_sel_array[j*MW +: MW] <= nxt_owner[j];
        end
      end
      m_grant <= nxt_grant;
      for (int i = 0; i < M; i++) begin
        if (nxt_grant[i]) begin
          s_sel_array[i*SW +: SW] <= tgt[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_xbar_arbiter.sv
// Bench for xbar_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_xbar_arbiter;
  localparam int M  = 3;
  localparam int S  = 2;
  localparam int MW = 2;
  localparam int SW = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [M-1:0]    m_req = '0;
  logic [SW*M-1:0] m_tgt = '0;
  logic [MW*S-1:0] m_sel_array;
  logic [SW*M-1:0] s_sel_array;
  logic [M-1:0]    m_grant;
  logic [S-1:0]    s_owned;

  // Second instance with S=3 so that an out-of-range target (3) is expressible.
  logic [2:0] m_req3 = '0;
  logic [5:0] m_tgt3 = '0;
  logic [5:0] m_sel_array3;
  logic [5:0] s_sel_array3;
  logic [2:0] m_grant3;
  logic [2:0] s_owned3;

  int n_checks = 0;
  int n_pass   = 0;

  int mo_owner [S];
  int mo_last  [S];
  int mo_msel  [S];
  int mo_ssel  [M];

  logic [11:0] got;
  assign got = {m_grant, s_owned, m_sel_array, s_sel_array};

  always #5 clk = ~clk;

  xbar_arbiter #(.M(M), .S(S)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req),
    .m_tgt       (m_tgt),
    .m_sel_array (m_sel_array),
    .s_sel_array (s_sel_array),
    .m_grant     (m_grant),
    .s_owned     (s_owned)
  );

  xbar_arbiter #(.M(3), .S(3)) u_dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .m_req       (m_req3),
    .m_tgt       (m_tgt3),
    .m_sel_array (m_sel_array3),
    .s_sel_array (s_sel_array3),
    .m_grant     (m_grant3),
    .s_owned     (s_owned3)
  );

  function automatic int tgt_of(input int i);
    return int'(m_tgt[i*SW +: SW]);
  endfunction

  task automatic model_reset();
    for (int j = 0; j < S; j++) begin
      mo_owner[j] = -1;
      mo_last[j]  = M - 1;
      mo_msel[j]  = 0;
    end
    for (int i = 0; i < M; i++) mo_ssel[i] = 0;
  endtask

  // Ownership rules: keep the owner while it still wants this slave, otherwise
  // hand the slave to the first requester after the last winner, wrapping mod M.
  task automatic model_edge();
    int cur, nw, c;
    for (int j = 0; j < S; j++) begin
      cur = mo_owner[j];
      if (!(cur >= 0 && m_req[cur] && tgt_of(cur) == j)) begin
        nw = -1;
        for (int k = 1; k <= M; k++) begin
          c = (mo_last[j] + k) % M;
          if (nw < 0 && m_req[c] && tgt_of(c) == j) nw = c;
        end
        mo_owner[j] = nw;
        if (nw >= 0) begin
          mo_last[j] = nw;
          mo_msel[j] = nw;
        end
      end
    end
    for (int j = 0; j < S; j++) begin
      if (mo_owner[j] >= 0) mo_ssel[mo_owner[j]] = j;
    end
  endtask

  function automatic logic [11:0] exp_vec();
    logic [2:0] g;
    logic [1:0] o;
    logic [3:0] ms;
    logic [2:0] ss;
    g = '0;
    o = '0;
    for (int j = 0; j < S; j++) begin
      if (mo_owner[j] >= 0) begin
        g[mo_owner[j]] = 1'b1;
        o[j] = 1'b1;
      end
      ms[j*2 +: 2] = 2'(mo_msel[j]);
    end
    for (int i = 0; i < M; i++) ss[i] = 1'(mo_ssel[i]);
    return {g, o, ms, ss};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic drive(input logic [2:0] r, input int t0, input int t1, input int t2);
    m_req = r;
    m_tgt = {1'(t2), 1'(t1), 1'(t0)};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int n = 0; n < 4; n++) begin
      m_req  = 3'($urandom);
      m_tgt  = 3'($urandom);
      m_req3 = 3'($urandom);
      m_tgt3 = 6'($urandom);
      tick();
      n_checks++;
      if (got !== 12'h000 || m_grant3 !== 3'b000 || s_owned3 !== 3'b000)
        $display("FAIL reset_hold cycle %0d got=%h grant3=%b owned3=%b want all 0", n, got, m_grant3, s_owned3);
      else n_pass++;
    end
    drive(3'b000, 0, 0, 0);
    m_req3 = '0;
    m_tgt3 = '0;
    rst_n  = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (got !== 12'h000) $display("FAIL reset_release got=%h want 000", got);
    else n_pass++;
    n_checks++;
    if (got !== exp_vec()) $display("FAIL reset_model got=%h want %h", got, exp_vec());
    else n_pass++;
  endtask

  task automatic test_single();
    drive(3'b001, 1, 0, 0);
    tick();
    n_checks++;
    if (m_grant !== 3'b001) $display("FAIL single_grant got=%b want 001", m_grant);
    else n_pass++;
    n_checks++;
    if (s_owned !== 2'b10) $display("FAIL single_owned got=%b want 10", s_owned);
    else n_pass++;
    n_checks++;
    if (m_sel_array[3:2] !== 2'd0) $display("FAIL single_msel1 got=%0d want 0", m_sel_array[3:2]);
    else n_pass++;
    n_checks++;
    if (s_sel_array[0] !== 1'b1) $display("FAIL single_ssel0 got=%b want 1", s_sel_array[0]);
    else n_pass++;
    drive(3'b000, 1, 0, 0);
    tick();
    n_checks++;
    if (m_grant !== 3'b000 || s_owned !== 2'b00)
      $display("FAIL single_release grant=%b owned=%b want 000/00", m_grant, s_owned);
    else n_pass++;
    n_checks++;
    if (got !== exp_vec()) $display("FAIL single_model got=%h want %h", got, exp_vec());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int seq [4] = '{0, 1, 2, 0};
    drive(3'b111, 0, 0, 0);
    tick();
    for (int n = 0; n < 4; n++) begin
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if (m_sel_array[1:0] !== 2'(seq[n]) || s_owned[0] !== 1'b1 || m_grant !== (3'b001 << seq[n]))
          $display("FAIL rr_owner step %0d.%0d owner=%0d owned=%b grant=%b want owner %0d", n, c,
                   m_sel_array[1:0], s_owned[0], m_grant, seq[n]);
        else n_pass++;
        n_checks++;
        if (got !== exp_vec()) $display("FAIL rr_model step %0d.%0d got=%h want %h", n, c, got, exp_vec());
        else n_pass++;
        if (c == 0) tick();
      end
      if (n < 3) begin
        drive(3'b111 & ~(3'b001 << seq[n]), 0, 0, 0);
        tick();
        drive(3'b111, 0, 0, 0);
      end
    end
    drive(3'b000, 0, 0, 0);
    tick();
    n_checks++;
    if (s_owned !== 2'b00) $display("FAIL rr_idle owned=%b want 00", s_owned);
    else n_pass++;
  endtask

  task automatic test_parallel();
    drive(3'b011, 0, 1, 0);
    tick();
    n_checks++;
    if (m_sel_array !== 4'b0100) $display("FAIL par_msel got=%b want 0100", m_sel_array);
    else n_pass++;
    n_checks++;
    if (s_sel_array[0] !== 1'b0 || s_sel_array[1] !== 1'b1)
      $display("FAIL par_ssel got=%b want x10", s_sel_array);
    else n_pass++;
    n_checks++;
    if (m_grant !== 3'b011 || s_owned !== 2'b11)
      $display("FAIL par_grant grant=%b owned=%b want 011/11", m_grant, s_owned);
    else n_pass++;
    drive(3'b000, 0, 0, 0);
    tick();
  endtask

  task automatic test_hold();
    drive(3'b100, 0, 0, 1);
    tick();
    n_checks++;
    if (m_grant !== 3'b100) $display("FAIL hold_first grant=%b want 100", m_grant);
    else n_pass++;
    drive(3'b101, 1, 0, 1);
    for (int n = 0; n < 10; n++) begin
      tick();
      n_checks++;
      if (m_grant !== 3'b100 || m_sel_array[3:2] !== 2'd2)
        $display("FAIL hold_wait cycle %0d grant=%b owner1=%0d want 100/2", n, m_grant, m_sel_array[3:2]);
      else n_pass++;
    end
    drive(3'b101, 1, 0, 0);
    tick();
    n_checks++;
    if (m_sel_array[3:2] !== 2'd0 || m_grant !== 3'b101 || s_owned !== 2'b11)
      $display("FAIL hold_handoff owner1=%0d grant=%b owned=%b want 0/101/11", m_sel_array[3:2], m_grant, s_owned);
    else n_pass++;
    n_checks++;
    if (got !== exp_vec()) $display("FAIL hold_model got=%h want %h", got, exp_vec());
    else n_pass++;
    drive(3'b000, 0, 0, 0);
    tick();
  endtask

  task automatic test_invalid_target();
    m_req3 = 3'b001;
    m_tgt3 = {2'd0, 2'd0, 2'd3};
    for (int n = 0; n < 6; n++) begin
      tick();
      n_checks++;
      if (m_grant3 !== 3'b000 || s_owned3 !== 3'b000)
        $display("FAIL invalid_tgt cycle %0d grant=%b owned=%b want 000/000", n, m_grant3, s_owned3);
      else n_pass++;
    end
    m_req3 = 3'b011;
    m_tgt3 = {2'd0, 2'd2, 2'd3};
    tick();
    n_checks++;
    if (m_grant3 !== 3'b010 || s_owned3 !== 3'b100 || m_sel_array3[5:4] !== 2'd1)
      $display("FAIL invalid_mixed grant=%b owned=%b owner2=%0d want 010/100/1", m_grant3, s_owned3, m_sel_array3[5:4]);
    else n_pass++;
    m_req3 = '0;
    tick();
  endtask

  task automatic test_midreset();
    drive(3'b011, 0, 1, 0);
    tick();
    n_checks++;
    if (m_grant !== 3'b011) $display("FAIL midrst_pre grant=%b want 011", m_grant);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (got !== 12'h000) $display("FAIL midrst_async got=%h want 000", got);
    else n_pass++;
    drive(3'b111, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (m_grant !== 3'b001 || m_sel_array[1:0] !== 2'd0)
      $display("FAIL midrst_restart grant=%b owner0=%0d want 001/0", m_grant, m_sel_array[1:0]);
    else n_pass++;
    n_checks++;
    if (got !== exp_vec()) $display("FAIL midrst_model got=%h want %h", got, exp_vec());
    else n_pass++;
    drive(3'b000, 0, 0, 0);
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) == 0) m_req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) m_tgt = 3'($urandom);
      tick();
      n_checks++;
      if (got !== exp_vec()) $display("FAIL random cycle %0d got=%h want %h", n, got, exp_vec());
      else n_pass++;
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (got !== 12'h000) $display("FAIL random_rst cycle %0d got=%h want 000", n, got);
        else n_pass++;
        rst_n = 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_parallel();
    test_hold();
    test_invalid_target();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
